// File: rtl/predict_scorer_pkg.sv
// Shared types for the predictor scorer: FSM state encoding and its width.
package predict_scorer_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        TRACK  = 2'd0,
        LOCKED = 2'd1,
        LOST   = 2'd2
    } scorer_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear (rst > clr > inc).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/predict_scorer.sv
// Scores a 1-bit predictor: saturating totals, windowed hit count and a lock FSM.
//  state  | meaning
//  TRACK  | searching; waiting for GOOD_HITS consecutive hits
//  LOCKED | predictor follows the stream
//  LOST   | MISS_LIMIT consecutive misses while locked; alarm raised
module predict_scorer
    import predict_scorer_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int WIN        = 64,
    parameter int GOOD_HITS  = 8,
    parameter int MISS_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic             guess,
    input  logic             result,
    input  logic             clear,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output logic [CNT_W-1:0] win_hits,
    output logic             win_done,
    output logic [ST_W-1:0]  state,
    output logic             alarm
);

    localparam logic [ST_W-1:0]  S_TRACK  = TRACK;
    localparam logic [ST_W-1:0]  S_LOCKED = LOCKED;
    localparam logic [ST_W-1:0]  S_LOST   = LOST;
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN - 1);
    localparam logic [CNT_W-1:0] GOOD_T   = CNT_W'(GOOD_HITS);
    localparam logic [CNT_W-1:0] MISS_T   = CNT_W'(MISS_LIMIT);

    logic             sample_hit;
    logic             sample_miss;
    logic [CNT_W-1:0] hstreak;
    logic [CNT_W-1:0] mstreak;
    logic [CNT_W-1:0] hs_next;
    logic [CNT_W-1:0] ms_next;
    logic [CNT_W-1:0] wpos;
    logic [CNT_W-1:0] wacc;
    logic [ST_W-1:0]  state_next;

    assign sample_hit  = valid && (guess == result);
    assign sample_miss = valid && (guess != result);

    // Totals drop samples that coincide with clear; streaks do not.
    sat_counter #(.W(CNT_W)) u_hit_cnt (
        .clk(clk), .rst(rst), .clr(clear), .inc(sample_hit), .q(hit_cnt)
    );
    sat_counter #(.W(CNT_W)) u_miss_cnt (
        .clk(clk), .rst(rst), .clr(clear), .inc(sample_miss), .q(miss_cnt)
    );
    sat_counter #(.W(CNT_W)) u_hstreak (
        .clk(clk), .rst(rst), .clr(sample_miss), .inc(sample_hit), .q(hstreak)
    );
    sat_counter #(.W(CNT_W)) u_mstreak (
        .clk(clk), .rst(rst), .clr(sample_hit), .inc(sample_miss), .q(mstreak)
    );

    // Next-streak values let the FSM move on the qualifying sample's own edge.
    always_comb begin
        hs_next = hstreak;
        ms_next = mstreak;
        if (sample_hit) begin
            hs_next = hstreak + CNT_W'(hstreak != '1);
            ms_next = '0;
        end else if (sample_miss) begin
            hs_next = '0;
            ms_next = mstreak + CNT_W'(mstreak != '1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_TRACK:  if (hs_next >= GOOD_T) state_next = S_LOCKED;
            S_LOCKED: if (ms_next >= MISS_T) state_next = S_LOST;
            S_LOST:   if (sample_hit)        state_next = S_TRACK;
            default:                         state_next = S_TRACK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_TRACK;
            alarm <= 1'b0;
        end else begin
            state <= state_next;
            alarm <= (state_next == S_LOST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wpos     <= '0;
            wacc     <= '0;
            win_hits <= '0;
            win_done <= 1'b0;
        end else if (valid) begin
            if (wpos == WIN_LAST) begin
                win_hits <= wacc + CNT_W'(sample_hit);
                win_done <= 1'b1;
                wpos     <= '0;
                wacc     <= '0;
            end else begin
                wpos     <= wpos + CNT_W'(1);
                wacc     <= wacc + CNT_W'(sample_hit);
                win_done <= 1'b0;
            end
        end else begin
            win_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_predict_scorer.sv
// Directed bench for predict_scorer (WIN=8) plus a CNT_W=4 instance for saturation.
module tb_predict_scorer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        guess = 1'b0;
    logic        result = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] hit_cnt, miss_cnt, win_hits;
    logic        win_done, alarm;
    logic [1:0]  state;
    logic [3:0]  hit_cnt4, miss_cnt4, win_hits4;
    logic        win_done4, alarm4;
    logic [1:0]  state4;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    predict_scorer #(.CNT_W(16), .WIN(8), .GOOD_HITS(8), .MISS_LIMIT(4)) dut (
        .clk(clk), .rst(rst), .valid(valid), .guess(guess), .result(result), .clear(clear),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .win_hits(win_hits), .win_done(win_done),
        .state(state), .alarm(alarm)
    );

    predict_scorer #(.CNT_W(4), .WIN(8), .GOOD_HITS(8), .MISS_LIMIT(4)) dut4 (
        .clk(clk), .rst(rst), .valid(valid), .guess(guess), .result(result), .clear(clear),
        .hit_cnt(hit_cnt4), .miss_cnt(miss_cnt4), .win_hits(win_hits4), .win_done(win_done4),
        .state(state4), .alarm(alarm4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic chk_all(input string tag, input int h, input int m, input int wh,
                           input int wd, input int st, input int al);
        chk({tag, ".hit_cnt"},  32'(hit_cnt),  32'(h));
        chk({tag, ".miss_cnt"}, 32'(miss_cnt), 32'(m));
        chk({tag, ".win_hits"}, 32'(win_hits), 32'(wh));
        chk({tag, ".win_done"}, 32'(win_done), 32'(wd));
        chk({tag, ".state"},    32'(state),    32'(st));
        chk({tag, ".alarm"},    32'(alarm),    32'(al));
    endtask

    // Apply inputs, clock once, then settle 1 time unit past the edge.
    task automatic step(input logic v, input logic g, input logic r, input logic c);
        valid = v; guess = g; result = r; clear = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        // 1: reset held 3 cycles, then one idle cycle
        do_reset(3);
        chk_all("rst", 0, 0, 0, 0, 0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk_all("post_rst", 0, 0, 0, 0, 0, 0);

        // 2: 8 samples, hits on even indices
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, (i % 2 == 0), 1'b0);
            if (i == 6) chk("win2.early_done", 32'(win_done), 32'd0);
        end
        chk_all("win2", 4, 4, 4, 1, 0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("win2.done_drop", 32'(win_done), 32'd0);

        // 3: lock, tolerate 3 misses, lose on 4th, recover on hit
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            if (i == 6) chk("lock.7th", 32'(state), 32'd0);
        end
        chk_all("lock.8th", 12, 4, 8, 1, 1, 0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        chk_all("lock.3miss", 12, 7, 8, 0, 1, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk_all("lost", 12, 8, 8, 0, 2, 1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("lost.idle_state", 32'(state), 32'd2);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk_all("recover", 13, 8, 8, 0, 0, 0);

        // 4: CNT_W=4 saturation over 20 hits
        do_reset(1);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("sat4.hit_cnt",  32'(hit_cnt4),  32'd15);
        chk("sat4.miss_cnt", 32'(miss_cnt4), 32'd0);
        chk("sat16.hit_cnt", 32'(hit_cnt),   32'd20);

        // 5: clear with a valid miss after 5 window samples
        do_reset(1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("clr.pre_hit", 32'(hit_cnt), 32'd5);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk_all("clr", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
        chk_all("clr.7after", 7, 0, 0, 0, 0, 0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk_all("clr.8after", 8, 0, 8, 1, 1, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // 6: idle with toggling guess/result -> outputs frozen
        for (int i = 0; i < 10; i++) begin
            step(1'b0, i[0], ~i[1], 1'b0);
            chk_all("idle", 8, 0, 8, 0, 1, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
